// File: rtl/cv32e40p_register_file_mp_sb.sv
// Multi-port flip-flop register file with optional FP bank, write-to-read bypass,
// per-register busy scoreboard and a sequential clear engine.
module cv32e40p_register_file_mp_sb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int BYPASS     = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]  raddr_i,
    output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_RPORTS-1:0]                  rbusy_o,
    input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_WPORTS-1:0]                  we_i,
    input  logic                                   rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]                  rsv_addr_i,
    output logic                                   rsv_ready_o,
    input  logic                                   clr_req_i,
    output logic                                   clr_busy_o
);

    localparam bit FP_BANK = (FPU != 0) && (ZFINX == 0);
    // Without an FP bank the address MSB is simply dropped, so both banks alias.
    localparam int IDX_W   = FP_BANK ? ADDR_WIDTH : ADDR_WIDTH - 1;
    localparam int NUM_TOT = 1 << IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, CLEAR} state_e;

    function automatic idx_t to_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[IDX_W-1:0];
    endfunction

    state_e                state_q;
    idx_t                  clr_idx_q;
    logic                  clr_busy_q;
    logic [DATA_WIDTH-1:0] mem_q [NUM_TOT];
    logic [DATA_WIDTH-1:0] mem_d [NUM_TOT];
    logic [NUM_TOT-1:0]    busy_q;
    logic [NUM_TOT-1:0]    busy_d;
    logic                  idle;
    idx_t                  rsv_idx;
    logic                  rsv_fire;

    // Index 0 is x0; f0 (index NUM_TOT/2 with an FP bank) is an ordinary register.
    always_comb begin
        idle        = (state_q == IDLE);
        rsv_idx     = to_idx(rsv_addr_i);
        rsv_ready_o = idle && (!busy_q[rsv_idx] || (rsv_idx == '0));
        rsv_fire    = rsv_valid_i && rsv_ready_o && (rsv_idx != '0);
    end

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (!idle) begin
            mem_d[clr_idx_q]  = '0;
            busy_d[clr_idx_q] = 1'b0;
        end else begin
            // Ascending loop: the highest-index port writing a register wins.
            for (int w = 0; w < NUM_WPORTS; w++) begin
                if (we_i[w] && (to_idx(waddr_i[w]) != '0)) begin
                    mem_d[to_idx(waddr_i[w])]  = wdata_i[w];
                    busy_d[to_idx(waddr_i[w])] = 1'b0;
                end
            end
            // A reservation arriving with a write to the same register must win.
            if (rsv_fire) begin
                busy_d[rsv_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TOT; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clr_idx_q  <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        state_q    <= CLEAR;
                        clr_idx_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == idx_t'(NUM_TOT - 1)) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy_o = clr_busy_q;

    // Bypass is suppressed while clearing because writes are being ignored then.
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rdata_o[p] = (to_idx(raddr_i[p]) == '0) ? '0 : mem_q[to_idx(raddr_i[p])];
            rbusy_o[p] = busy_q[to_idx(raddr_i[p])];
            if ((BYPASS != 0) && idle && (to_idx(raddr_i[p]) != '0)) begin
                for (int w = 0; w < NUM_WPORTS; w++) begin
                    if (we_i[w] && (to_idx(waddr_i[w]) == to_idx(raddr_i[p]))) begin
                        rdata_o[p] = wdata_i[w];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_register_file_mp_sb.sv
// Directed bench: one integer-only non-bypass instance and one FP-bank bypass instance
// driven from shared inputs, each checked against hand-computed values.
module tb_cv32e40p_register_file_mp_sb;

  logic                  clk;
  logic                  rst_n;
  logic [2:0][5:0]       raddr;
  logic [2:0][31:0]      rdata_a, rdata_b;
  logic [2:0]            rbusy_a, rbusy_b;
  logic [1:0][5:0]       waddr;
  logic [1:0][31:0]      wdata;
  logic [1:0]            we;
  logic                  rsv_valid;
  logic [5:0]            rsv_addr;
  logic                  rsv_ready_a, rsv_ready_b;
  logic                  clr_req;
  logic                  clr_busy_a, clr_busy_b;

  int total = 0;
  int bad   = 0;
  int cnt_a, cnt_b;

  cv32e40p_register_file_mp_sb #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(0), .ZFINX(0),
    .NUM_RPORTS(3), .NUM_WPORTS(2), .BYPASS(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_a),
    .clr_req_i(clr_req), .clr_busy_o(clr_busy_a)
  );

  cv32e40p_register_file_mp_sb #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(0),
    .NUM_RPORTS(3), .NUM_WPORTS(2), .BYPASS(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_b),
    .clr_req_i(clr_req), .clr_busy_o(clr_busy_b)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input int port, input logic [5:0] addr, input logic [31:0] data);
    waddr[port] = addr;
    wdata[port] = data;
    we          = 2'b00;
    we[port]    = 1'b1;
    next_cycle();
    we = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 64; a++) begin
      raddr[0] = 6'(a);
      raddr[1] = 6'(a);
      raddr[2] = 6'(63 - a);
      #1;
      check({tag, "_rdata_a"}, rdata_a[0], 32'h0);
      check({tag, "_rdata_b"}, rdata_b[1], 32'h0);
      check({tag, "_rbusy"}, {26'h0, rbusy_a, rbusy_b}, 32'h0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    raddr     = '0;
    waddr     = '0;
    wdata     = '0;
    we        = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    clr_req   = 1'b0;
    #2;

    // reset state
    check_all_zero("rst");
    check("rst_ready_a", rsv_ready_a, 1'b1);
    check("rst_ready_b", rsv_ready_b, 1'b1);
    check("rst_clr_a", clr_busy_a, 1'b0);
    check("rst_clr_b", clr_busy_b, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // same-edge writes: port 1 wins
    waddr[0] = 6'd5; wdata[0] = 32'hA5A5_A5A5;
    waddr[1] = 6'd5; wdata[1] = 32'h0000_1111;
    we = 2'b11;
    raddr[0] = 6'd5;
    #1;
    check("same_pre_a", rdata_a[0], 32'h0);
    check("same_byp_b", rdata_b[0], 32'h0000_1111);
    next_cycle();
    we = 2'b00;
    #1;
    check("same_post_a", rdata_a[0], 32'h0000_1111);
    check("same_post_b", rdata_b[0], 32'h0000_1111);

    // x0
    waddr[0] = 6'd0; wdata[0] = 32'hFFFF_FFFF; we = 2'b01;
    raddr[0] = 6'd0;
    #1;
    check("x0_byp_b", rdata_b[0], 32'h0);
    next_cycle();
    we = 2'b00;
    #1;
    check("x0_rd_a", rdata_a[0], 32'h0);
    check("x0_rd_b", rdata_b[0], 32'h0);
    rsv_valid = 1'b1; rsv_addr = 6'd0;
    #1;
    check("x0_rsv_a", rsv_ready_a, 1'b1);
    check("x0_rsv_b", rsv_ready_b, 1'b1);
    next_cycle();
    rsv_valid = 1'b0;
    #1;
    check("x0_busy_a", rbusy_a[0], 1'b0);
    check("x0_busy_b", rbusy_b[0], 1'b0);

    // reserve / refuse x7
    rsv_valid = 1'b1; rsv_addr = 6'd7;
    #1;
    check("rsv7_ready_a", rsv_ready_a, 1'b1);
    next_cycle();
    raddr[1] = 6'd7;
    #1;
    check("rsv7_busy_a", rbusy_a[1], 1'b1);
    check("rsv7_busy_b", rbusy_b[1], 1'b1);
    check("rsv7_refuse_a", rsv_ready_a, 1'b0);
    check("rsv7_refuse_b", rsv_ready_b, 1'b0);
    rsv_valid = 1'b0;

    // release via port 0; busy is not masked in the write cycle
    waddr[0] = 6'd7; wdata[0] = 32'h0000_1234; we = 2'b01;
    #1;
    check("rel_same_cyc_a", rbusy_a[1], 1'b1);
    next_cycle();
    we = 2'b00;
    #1;
    check("rel_busy_a", rbusy_a[1], 1'b0);
    check("rel_busy_b", rbusy_b[1], 1'b0);
    check("rel_data_a", rdata_a[1], 32'h0000_1234);
    check("rel_data_b", rdata_b[1], 32'h0000_1234);

    // reserve and write x7 in one cycle
    rsv_valid = 1'b1; rsv_addr = 6'd7;
    waddr[0] = 6'd7; wdata[0] = 32'h0000_5678; we = 2'b01;
    #1;
    check("conf_ready_a", rsv_ready_a, 1'b1);
    next_cycle();
    rsv_valid = 1'b0; we = 2'b00;
    #1;
    check("conf_data_a", rdata_a[1], 32'h0000_5678);
    check("conf_busy_a", rbusy_a[1], 1'b1);
    check("conf_busy_b", rbusy_b[1], 1'b1);

    // release via port 1
    write1(1, 6'd7, 32'h0000_9ABC);
    #1;
    check("rel1_busy_a", rbusy_a[1], 1'b0);
    check("rel1_data_b", rdata_b[1], 32'h0000_9ABC);

    // FP bank vs aliasing
    write1(0, 6'h01, 32'h1111_1111);
    write1(0, 6'h21, 32'hDEAD_BEEF);
    raddr[0] = 6'h21; raddr[1] = 6'h01;
    #1;
    check("fp21_a", rdata_a[0], 32'hDEAD_BEEF);
    check("fp01_a", rdata_a[1], 32'hDEAD_BEEF);
    check("fp21_b", rdata_b[0], 32'hDEAD_BEEF);
    check("fp01_b", rdata_b[1], 32'h1111_1111);

    // f0 is ordinary with an FP bank, x0 without
    write1(0, 6'h20, 32'hCAFE_0000);
    raddr[2] = 6'h20;
    #1;
    check("f0_rd_a", rdata_a[2], 32'h0);
    check("f0_rd_b", rdata_b[2], 32'hCAFE_0000);
    rsv_valid = 1'b1; rsv_addr = 6'h20;
    #1;
    check("f0_rsv_a", rsv_ready_a, 1'b1);
    check("f0_rsv_b", rsv_ready_b, 1'b1);
    next_cycle();
    #1;
    check("f0_busy_a", rbusy_a[2], 1'b0);
    check("f0_busy_b", rbusy_b[2], 1'b1);
    check("f0_rersv_a", rsv_ready_a, 1'b1);
    check("f0_rersv_b", rsv_ready_b, 1'b0);
    rsv_valid = 1'b0;

    // fill every register
    for (int a = 1; a < 64; a++) begin
      write1(0, 6'(a), 32'hA000_0000 | 32'(a));
    end
    raddr[0] = 6'd5; raddr[1] = 6'd63; raddr[2] = 6'h20;
    #1;
    check("fill5_a", rdata_a[0], 32'hA000_0025);
    check("fill5_b", rdata_b[0], 32'hA000_0005);
    check("fill63_a", rdata_a[1], 32'hA000_003F);
    check("fill63_b", rdata_b[1], 32'hA000_003F);
    check("fill_f0_busy_b", rbusy_b[2], 1'b0);
    rsv_valid = 1'b1; rsv_addr = 6'd9;
    next_cycle();
    rsv_valid = 1'b0;
    raddr[2] = 6'd9;
    #1;
    check("fill_rsv9_a", rbusy_a[2], 1'b1);
    check("fill_rsv9_b", rbusy_b[2], 1'b1);

    // clear engine; writes, reservations and repeat requests are ignored meanwhile
    raddr[0] = 6'd20;
    clr_req = 1'b1;
    next_cycle();
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 80; k++) begin
      clr_req = (k < 4);
      if (k < 30) begin
        waddr[0] = 6'd2; waddr[1] = 6'd2;
        wdata[0] = 32'hFFFF_FFFF; wdata[1] = 32'hFFFF_FFFF;
        we = 2'b11;
        rsv_valid = 1'b1; rsv_addr = 6'd4;
      end else begin
        we = 2'b00;
        rsv_valid = 1'b0;
      end
      #1;
      if (k == 0) begin
        check("clr_ready_a", rsv_ready_a, 1'b0);
        check("clr_ready_b", rsv_ready_b, 1'b0);
      end
      if (k == 10) begin
        check("clr_part_a", rdata_a[0], 32'hA000_0034);
        check("clr_part_b", rdata_b[0], 32'hA000_0014);
      end
      if (k == 25) begin
        check("clr_done20_a", rdata_a[0], 32'h0);
      end
      cnt_a += int'(clr_busy_a);
      cnt_b += int'(clr_busy_b);
      next_cycle();
    end
    check("clr_len_a", cnt_a, 32'd32);
    check("clr_len_b", cnt_b, 32'd64);
    check("clr_end_a", clr_busy_a, 1'b0);
    check("clr_end_b", clr_busy_b, 1'b0);
    check_all_zero("clr");
    check("clr_post_ready_a", rsv_ready_a, 1'b1);
    check("clr_post_ready_b", rsv_ready_b, 1'b1);

    // async reset in the middle of a clear
    write1(0, 6'd20, 32'h0000_2020);
    rsv_valid = 1'b1; rsv_addr = 6'd10;
    next_cycle();
    rsv_valid = 1'b0;
    clr_req = 1'b1;
    next_cycle();
    clr_req = 1'b0;
    repeat (5) next_cycle();
    raddr[0] = 6'd20; raddr[1] = 6'd10;
    #1;
    check("mid_busy_a", clr_busy_a, 1'b1);
    check("mid_data_b", rdata_b[0], 32'h0000_2020);
    rst_n = 1'b0;
    #1;
    check("mrst_clr_a", clr_busy_a, 1'b0);
    check("mrst_clr_b", clr_busy_b, 1'b0);
    check("mrst_ready_a", rsv_ready_a, 1'b1);
    check("mrst_data_a", rdata_a[0], 32'h0);
    check("mrst_data_b", rdata_b[0], 32'h0);
    check("mrst_busy_a", rbusy_a[1], 1'b0);
    check("mrst_busy_b", rbusy_b[1], 1'b0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    repeat (3) next_cycle();
    check("mrst_norun_a", clr_busy_a, 1'b0);
    check("mrst_norun_b", clr_busy_b, 1'b0);
    write1(0, 6'd20, 32'h0000_0055);
    #1;
    check("mrst_wr_a", rdata_a[0], 32'h0000_0055);
    check("mrst_wr_b", rdata_b[0], 32'h0000_0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
